// File: rtl/tsc_multicycle_control.sv
// ---------------------------------------------------------------------------
// tsc_multicycle_control
//
// Multi-cycle control FSM for the TSC datapath. It steps one state per clock
// through IF -> ID -> EX -> MEM -> WB, decodes the instruction word that the
// datapath has latched, and drives every datapath control input. It stalls
// in IF and MEM until memory reports completion, counts retired instructions
// and owns the halt condition.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   inst         latched instruction: op=[15:12] rs=[11:10] rt=[9:8]
//                rd=[7:6] func=[5:0]
//   mem_ready    memory finished the current read/write this cycle
//   PVSWriteEn, jump, branch, WWD, HLT, MemRead, MemWrite, RegWrite,
//   MemDest, JumpDest, carry               1-bit datapath controls
//   MemToReg, RegDest, Bcond, ALUSrcA, ALUSrcB  2-bit datapath selects
//   ALUOp        ALU function
//   num_inst     retired-instruction count (wraps)
//   is_halted    set once HLT retires
//   err_timeout  sticky flag: an IF stall reached IF_TIMEOUT cycles
// ---------------------------------------------------------------------------
module tsc_multicycle_control #(
    parameter int WORD       = 16,
    parameter int IF_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [WORD-1:0] inst,
    input  logic            mem_ready,
    output logic            PVSWriteEn,
    output logic            jump,
    output logic            branch,
    output logic            WWD,
    output logic            HLT,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            MemDest,
    output logic            JumpDest,
    output logic            carry,
    output logic [1:0]      MemToReg,
    output logic [1:0]      RegDest,
    output logic [1:0]      Bcond,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [3:0]      ALUOp,
    output logic [WORD-1:0] num_inst,
    output logic            is_halted,
    output logic            err_timeout
);

    // Stall counter is wide enough to reach IF_TIMEOUT and then saturate.
    localparam int               CNT_W     = $clog2(IF_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(IF_TIMEOUT);

    typedef enum logic [2:0] {
        S_IF,
        S_ID,
        S_EX,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [WORD-1:0]  num_q, num_d;
    logic             halted_q, halted_d;
    logic             err_q, err_d;

    logic [3:0] op;
    logic [5:0] func;
    logic       unused_fields;
    logic       is_r_alu, is_imm, is_lwd, is_swd, is_br, is_jmp, is_jal;
    logic       is_jpr, is_jrl, is_wwd, is_hlt, is_legal;

    assign op   = inst[15:12];
    assign func = inst[5:0];
    // Register specifiers are consumed by the datapath, not by control.
    assign unused_fields = ^inst[11:6];

    always_comb begin
        is_br    = (op < 4'd4);
        is_imm   = (op >= 4'd4) && (op <= 4'd6);
        is_lwd   = (op == 4'd7);
        is_swd   = (op == 4'd8);
        is_jmp   = (op == 4'd9);
        is_jal   = (op == 4'd10);
        is_r_alu = (op == 4'd15) && (func < 6'd8);
        is_jpr   = (op == 4'd15) && (func == 6'd25);
        is_jrl   = (op == 4'd15) && (func == 6'd26);
        is_wwd   = (op == 4'd15) && (func == 6'd28);
        is_hlt   = (op == 4'd15) && (func == 6'd29);
        is_legal = is_br | is_imm | is_lwd | is_swd | is_jmp | is_jal |
                   is_r_alu | is_jpr | is_jrl | is_wwd | is_hlt;
    end

    always_comb begin
        state_d    = state_q;
        stall_d    = stall_q;
        err_d      = err_q;
        PVSWriteEn = 1'b0;
        jump       = 1'b0;
        branch     = 1'b0;
        WWD        = 1'b0;
        HLT        = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        MemDest    = 1'b0;
        JumpDest   = 1'b0;
        carry      = 1'b0;
        MemToReg   = 2'b00;
        RegDest    = 2'b00;
        Bcond      = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUOp      = 4'd0;

        // Outputs are forced to zero for as long as reset is held, even
        // though the state register already reads IF.
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    MemRead = 1'b1;
                    if (mem_ready) begin
                        state_d = S_ID;
                        stall_d = '0;
                    end else begin
                        if (stall_q != {CNT_W{1'b1}}) stall_d = stall_q + 1'b1;
                        if ((IF_TIMEOUT != 0) && (stall_d >= TIMEOUT_C)) err_d = 1'b1;
                    end
                end
                S_ID: begin
                    // ALU selects stay at PC + 1 (all zero) for the jump link value.
                    if (is_jmp || is_jal) begin
                        jump       = 1'b1;
                        PVSWriteEn = 1'b1;
                        state_d    = S_IF;
                    end else if (is_jpr || is_jrl) begin
                        jump       = 1'b1;
                        JumpDest   = 1'b1;
                        PVSWriteEn = 1'b1;
                        state_d    = S_IF;
                    end else if (is_hlt) begin
                        HLT     = 1'b1;
                        state_d = S_HALT;
                    end else if (!is_legal) begin
                        PVSWriteEn = 1'b1;   // retire as a NOP
                        state_d    = S_IF;
                    end else begin
                        state_d = S_EX;
                    end
                    if (is_jal || is_jrl) begin
                        RegWrite = 1'b1;
                        RegDest  = 2'b10;
                        MemToReg = 2'b10;
                    end
                end
                S_EX: begin
                    ALUSrcA = 2'b01;
                    state_d = S_IF;
                    if (is_r_alu) begin
                        ALUSrcB = 2'b01;
                        ALUOp   = func[3:0];
                        carry   = (func[3:0] == 4'd1) || (func[3:0] == 4'd5);
                        state_d = S_WB;
                    end else if (is_imm) begin
                        ALUSrcB = (op == 4'd6) ? 2'b11 : 2'b10;
                        ALUOp   = (op == 4'd5) ? 4'd8 : 4'd0;
                        state_d = S_WB;
                    end else if (is_lwd || is_swd) begin
                        ALUSrcB = 2'b10;
                        state_d = S_MEM;
                    end else if (is_br) begin
                        ALUSrcB    = 2'b01;
                        ALUOp      = 4'd1;
                        branch     = 1'b1;
                        Bcond      = op[1:0];
                        PVSWriteEn = 1'b1;
                    end else if (is_wwd) begin
                        WWD        = 1'b1;
                        PVSWriteEn = 1'b1;
                    end
                end
                S_MEM: begin
                    MemDest = 1'b1;
                    if (is_swd) MemWrite = 1'b1;
                    else        MemRead  = 1'b1;
                    if (mem_ready) begin
                        if (is_swd) begin
                            PVSWriteEn = 1'b1;
                            state_d    = S_IF;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    RegWrite   = 1'b1;
                    PVSWriteEn = 1'b1;
                    MemToReg   = is_lwd ? 2'b01 : 2'b00;
                    RegDest    = is_r_alu ? 2'b01 : 2'b00;
                    state_d    = S_IF;
                end
                S_HALT: state_d = S_HALT;
                default: state_d = S_IF;
            endcase
        end

        num_d    = num_q + {{(WORD-1){1'b0}}, (PVSWriteEn | HLT)};
        halted_d = halted_q | HLT;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IF;
            stall_q  <= '0;
            num_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stall_q  <= stall_d;
            num_q    <= num_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign num_inst    = num_q;
    assign is_halted   = halted_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_tsc_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_tsc_multicycle_control
//
// Randomized bench for tsc_multicycle_control. A reference model expands each
// instruction into its expected cycle-by-cycle control trace and pushes one
// expected record per cycle into a queue; a monitor pops and compares on every
// falling edge. Reset behaviour is checked directly in the stimulus process.
// ---------------------------------------------------------------------------
module tb_tsc_multicycle_control;

    localparam int WORD       = 16;
    localparam int IF_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] inst;
    logic        mem_ready;
    logic        PVSWriteEn, jump, branch, WWD, HLT, MemRead, MemWrite;
    logic        RegWrite, MemDest, JumpDest, carry;
    logic [1:0]  MemToReg, RegDest, Bcond, ALUSrcA, ALUSrcB;
    logic [3:0]  ALUOp;
    logic [15:0] num_inst;
    logic        is_halted, err_timeout;

    always #5 clk = ~clk;

    tsc_multicycle_control #(.WORD(WORD), .IF_TIMEOUT(IF_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .inst(inst), .mem_ready(mem_ready),
        .PVSWriteEn(PVSWriteEn), .jump(jump), .branch(branch), .WWD(WWD),
        .HLT(HLT), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .MemDest(MemDest), .JumpDest(JumpDest), .carry(carry),
        .MemToReg(MemToReg), .RegDest(RegDest), .Bcond(Bcond),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .num_inst(num_inst), .is_halted(is_halted), .err_timeout(err_timeout)
    );

    typedef struct packed {
        logic       pvs, jump, branch, wwd, hlt, mrd, mwr, rwr, mdest, jdest, carry;
        logic [1:0] m2r, rdst, bcond, asa, asb;
        logic [3:0] aluop;
    } ctl_t;

    typedef struct packed {
        ctl_t        ctl;
        logic [15:0] num;
        logic        halted;
        logic        err;
    } exp_t;

    typedef enum int {
        K_RALU, K_ADI, K_ORI, K_LHI, K_LWD, K_SWD, K_BR,
        K_JMP, K_JAL, K_JPR, K_JRL, K_WWD, K_HLT, K_ILL
    } kind_t;

    ctl_t act_ctl;
    assign act_ctl = {PVSWriteEn, jump, branch, WWD, HLT, MemRead, MemWrite,
                      RegWrite, MemDest, JumpDest, carry, MemToReg, RegDest,
                      Bcond, ALUSrcA, ALUSrcB, ALUOp};

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] num_m;
    logic        halted_m, err_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: the DUT presents a full control word every cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ctl",         32'(act_ctl),     32'(e.ctl));
                chk("num_inst",    32'(num_inst),    32'(e.num));
                chk("is_halted",   32'(is_halted),   32'(e.halted));
                chk("err_timeout", 32'(err_timeout), 32'(e.err));
            end
        end
    end

    function automatic kind_t classify(input logic [15:0] w);
        logic [3:0] op;
        logic [5:0] f;
        op = w[15:12];
        f  = w[5:0];
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: return K_BR;
            4'd4:  return K_ADI;
            4'd5:  return K_ORI;
            4'd6:  return K_LHI;
            4'd7:  return K_LWD;
            4'd8:  return K_SWD;
            4'd9:  return K_JMP;
            4'd10: return K_JAL;
            4'd15: begin
                if (f < 6'd8)   return K_RALU;
                if (f == 6'd25) return K_JPR;
                if (f == 6'd26) return K_JRL;
                if (f == 6'd28) return K_WWD;
                if (f == 6'd29) return K_HLT;
                return K_ILL;
            end
            default: return K_ILL;
        endcase
    endfunction

    function automatic logic [15:0] rand_inst();
        logic [15:0] w;
        int          sel;
        w         = 16'($urandom);
        w[15:12]  = 4'($urandom_range(0, 15));
        if (w[15:12] == 4'd15) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: w[5:0] = 6'($urandom_range(0, 7));
                1: w[5:0] = 6'd25;
                2: w[5:0] = 6'd26;
                3: w[5:0] = 6'd28;
                4: w[5:0] = 6'($urandom_range(8, 24));
                default: w[5:0] = 6'($urandom_range(30, 63));
            endcase
        end
        return w;
    endfunction

    // One clock of stimulus: queue what the DUT must show this cycle, drive
    // mem_ready, let the edge pass, then account for retirement.
    task automatic step(input ctl_t c, input logic mr, input logic err_e);
        exp_t e;
        e.ctl    = c;
        e.num    = num_m;
        e.halted = halted_m;
        e.err    = err_e;
        mem_ready = mr;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        if (c.pvs || c.hlt) num_m = num_m + 16'd1;
        if (c.hlt) halted_m = 1'b1;
    endtask

    // Expand one instruction into its expected trace.
    task automatic run_inst(input logic [15:0] w, input int s_if, input int s_mem);
        kind_t k;
        ctl_t  c;
        k    = classify(w);
        inst = w;
        for (int i = 0; i <= s_if; i++) begin
            c = '0;
            c.mrd = 1'b1;
            step(c, i == s_if, err_m || (i >= IF_TIMEOUT));
        end
        if (s_if >= IF_TIMEOUT) err_m = 1'b1;

        c = '0;
        case (k)
            K_JMP: begin c.jump = 1; c.pvs = 1; end
            K_JAL: begin c.jump = 1; c.pvs = 1; c.rwr = 1; c.rdst = 2'b10; c.m2r = 2'b10; end
            K_JPR: begin c.jump = 1; c.jdest = 1; c.pvs = 1; end
            K_JRL: begin c.jump = 1; c.jdest = 1; c.pvs = 1; c.rwr = 1; c.rdst = 2'b10; c.m2r = 2'b10; end
            K_HLT: c.hlt = 1;
            K_ILL: c.pvs = 1;
            default: ;
        endcase
        step(c, 1'($urandom), err_m);
        if (k inside {K_JMP, K_JAL, K_JPR, K_JRL, K_HLT, K_ILL}) return;

        c = '0;
        c.asa = 2'b01;
        case (k)
            K_RALU: begin
                c.asb   = 2'b01;
                c.aluop = w[3:0];
                c.carry = (w[5:0] == 6'd1) || (w[5:0] == 6'd5);
            end
            K_ADI: c.asb = 2'b10;
            K_ORI: begin c.asb = 2'b10; c.aluop = 4'd8; end
            K_LHI: c.asb = 2'b11;
            K_LWD, K_SWD: c.asb = 2'b10;
            K_BR: begin
                c.asb = 2'b01; c.aluop = 4'd1; c.branch = 1;
                c.bcond = w[13:12]; c.pvs = 1;
            end
            K_WWD: begin c.wwd = 1; c.pvs = 1; end
            default: ;
        endcase
        step(c, 1'($urandom), err_m);
        if (k == K_BR || k == K_WWD) return;

        if (k == K_LWD || k == K_SWD) begin
            for (int i = 0; i <= s_mem; i++) begin
                c = '0;
                c.mdest = 1'b1;
                if (k == K_SWD) begin
                    c.mwr = 1'b1;
                    c.pvs = (i == s_mem);
                end else begin
                    c.mrd = 1'b1;
                end
                step(c, i == s_mem, err_m);
            end
            if (k == K_SWD) return;
        end

        c = '0;
        c.rwr  = 1'b1;
        c.pvs  = 1'b1;
        c.m2r  = (k == K_LWD)  ? 2'b01 : 2'b00;
        c.rdst = (k == K_RALU) ? 2'b01 : 2'b00;
        step(c, 1'($urandom), err_m);
    endtask

    initial begin
        ctl_t c;
        reset     = 1'b1;
        inst      = 16'h0000;
        mem_ready = 1'b0;
        num_m     = 16'd0;
        halted_m  = 1'b0;
        err_m     = 1'b0;

        // Reset state, with mem_ready high to show it is ignored.
        mem_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_ctl",         32'(act_ctl),     32'd0);
        chk("reset_num_inst",    32'(num_inst),    32'd0);
        chk("reset_is_halted",   32'(is_halted),   32'd0);
        chk("reset_err_timeout", 32'(err_timeout), 32'd0);
        reset = 1'b0;

        // Directed instructions.
        run_inst(16'hF1C0, 0, 0);
        chk("add_retired", 32'(num_inst), 32'd1);
        run_inst(16'h7105, 0, 3);
        run_inst(16'h1103, 0, 0);
        run_inst(16'hA010, 0, 0);

        // Randomized instruction stream with random IF/MEM stalls.
        for (int n = 0; n < 150; n++)
            run_inst(rand_inst(), $urandom_range(0, 3), $urandom_range(0, 3));

        // Reset asserted while an SWD waits in MEM.
        inst = 16'h8105;
        c = '0; c.mrd = 1;                                   step(c, 1'b1, err_m);
        c = '0;                                              step(c, 1'b0, err_m);
        c = '0; c.asa = 2'b01; c.asb = 2'b10;                step(c, 1'b0, err_m);
        c = '0; c.mdest = 1; c.mwr = 1;                      step(c, 1'b0, err_m);
        #1;
        chk("swd_mem_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        chk("swd_reset_memwrite", 32'(MemWrite), 32'd0);
        chk("swd_reset_ctl",      32'(act_ctl),  32'd0);
        chk("swd_reset_num_inst", 32'(num_inst), 32'd0);
        mem_ready = 1'b1;
        @(posedge clk);
        #2;
        chk("reset_hold_num_inst", 32'(num_inst), 32'd0);
        chk("reset_hold_ctl",      32'(act_ctl),  32'd0);
        reset    = 1'b0;
        num_m    = 16'd0;
        halted_m = 1'b0;
        err_m    = 1'b0;

        // Long IF stall crosses the timeout threshold.
        run_inst(16'hF1C0, 258, 0);
        chk("err_timeout_sticky", 32'(err_timeout), 32'd1);
        for (int n = 0; n < 20; n++)
            run_inst(rand_inst(), $urandom_range(0, 2), $urandom_range(0, 2));

        // Halt, then stay frozen regardless of mem_ready and inst.
        run_inst(16'hF01D, 0, 0);
        for (int n = 0; n < 20; n++) begin
            inst = 16'($urandom);
            step(ctl_t'(0), 1'($urandom), err_m);
        end

        // Reset leaves the halted state and clears all status.
        reset = 1'b1;
        #1;
        chk("halt_reset_is_halted",   32'(is_halted),   32'd0);
        chk("halt_reset_num_inst",    32'(num_inst),    32'd0);
        chk("halt_reset_err_timeout", 32'(err_timeout), 32'd0);
        @(posedge clk);
        #2;
        reset    = 1'b0;
        num_m    = 16'd0;
        halted_m = 1'b0;
        err_m    = 1'b0;
        run_inst(16'hF1C0, 1, 0);

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
